// File: rtl/inject_queue_if.sv
// Push-side and router-side signals of one inject_queue instance.
// The producer/router end uses master; the queue uses slave.
interface inject_queue_if #(
  parameter int DATA_W  = 32,
  parameter int CYCLE_W = 16,
  parameter int OP_W    = 2
);
  logic               wr_valid;
  logic               wr_ready;
  logic [DATA_W-1:0]  wr_data;
  logic [CYCLE_W-1:0] wr_cycle;
  logic               can_inject;
  logic [OP_W-1:0]    op;
  logic [DATA_W-1:0]  data;
  logic [CYCLE_W-1:0] in_cycle;

  modport master (
    output wr_valid, wr_data, wr_cycle, can_inject,
    input  wr_ready, op, data, in_cycle
  );

  modport slave (
    input  wr_valid, wr_data, wr_cycle, can_inject,
    output wr_ready, op, data, in_cycle
  );
endinterface

// File: rtl/inject_queue.sv
// inject_queue: timestamped packet FIFO that releases each packet to one router once due.
// Optional macro INJ_STATS_EN adds saturating injected/stall counters cleared by stat_clr_i.
module inject_queue #(
  parameter int DATA_W  = 32,
  parameter int CYCLE_W = 16,
  parameter int OP_W    = 2,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inject_queue_if.slave          bus,
  input  logic [CYCLE_W-1:0]     cur_cycle_i,
  output logic [$clog2(DEPTH):0] count_o
`ifdef INJ_STATS_EN
  ,
  input  logic                   stat_clr_i,
  output logic [31:0]            stat_injected_o,
  output logic [31:0]            stat_stall_o
`endif
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);
  localparam logic [OP_W-1:0]  OP_NOP    = '0;
  localparam logic [OP_W-1:0]  OP_INJECT = OP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BLOCKED, S_ISSUE} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  dataMem_q  [DEPTH];
  logic [CYCLE_W-1:0] cycleMem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
  logic [PTR_W-1:0]   count_q, count_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CYCLE_W-1:0] inCycle_q, inCycle_d;
  logic               wrReady, push, pop, due;
  logic [DATA_W-1:0]  headData;
  logic [CYCLE_W-1:0] headCycle, cycleDiff;

  // Refusal is based on registered occupancy only, so a same-cycle pop never frees a slot.
  assign wrReady   = (count_q != FULL_CNT);
  assign push      = bus.wr_valid && wrReady;
  assign pop       = (state_q == S_ISSUE);
  assign headData  = dataMem_q[rdPtr_q[AW-1:0]];
  assign headCycle = cycleMem_q[rdPtr_q[AW-1:0]];
  // Modular difference keeps the due test correct across cur_cycle wrap.
  assign cycleDiff = cur_cycle_i - headCycle;
  assign due       = ~cycleDiff[CYCLE_W-1];
  assign count_d   = count_q + PTR_W'(push) - PTR_W'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      dataMem_q[wrPtr_q[AW-1:0]]  <= bus.wr_data;
      cycleMem_q[wrPtr_q[AW-1:0]] <= bus.wr_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      op_q      <= OP_NOP;
      data_q    <= '0;
      inCycle_q <= '0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_q + PTR_W'(push);
      rdPtr_q   <= rdPtr_q + PTR_W'(pop);
      count_q   <= count_d;
      op_q      <= op_d;
      data_q    <= data_d;
      inCycle_q <= inCycle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = OP_NOP;
    data_d    = data_q;
    inCycle_d = inCycle_q;
    unique case (state_q)
      S_IDLE:    if (push) state_d = S_WAIT;
      S_WAIT:    if (due) state_d = bus.can_inject ? S_ISSUE : S_BLOCKED;
      S_BLOCKED: if (bus.can_inject) state_d = S_ISSUE;
      S_ISSUE: begin
        op_d      = OP_INJECT;
        data_d    = headData;
        inCycle_d = headCycle;
        state_d   = (count_d == '0) ? S_IDLE : S_WAIT;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  assign bus.wr_ready = wrReady;
  assign bus.op       = op_q;
  assign bus.data     = data_q;
  assign bus.in_cycle = inCycle_q;
  assign count_o      = count_q;

`ifdef INJ_STATS_EN
  logic [31:0] statInjected_q, statStall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statInjected_q <= '0;
      statStall_q    <= '0;
    end else if (stat_clr_i) begin
      statInjected_q <= '0;
      statStall_q    <= '0;
    end else begin
      if (pop && (statInjected_q != '1)) statInjected_q <= statInjected_q + 32'd1;
      if ((state_q == S_BLOCKED) && (statStall_q != '1)) statStall_q <= statStall_q + 32'd1;
    end
  end

  assign stat_injected_o = statInjected_q;
  assign stat_stall_o    = statStall_q;
`endif
endmodule
